// File: rtl/lock_round_if.sv
// Handshake bundle between the game state manager / player inputs and the
// lock round sequencer: round start, coder code entry, breaker guess entry
// and the guess-consumed acknowledge.
interface lock_round_if #(
  parameter int CODE_W = 4
);
  logic              start;
  logic [CODE_W-1:0] code_in;
  logic              code_valid;
  logic [CODE_W-1:0] guess_in;
  logic              guess_valid;
  logic              guess_ack;

  modport master (
    output start, code_in, code_valid, guess_in, guess_valid,
    input  guess_ack
  );

  modport slave (
    input  start, code_in, code_valid, guess_in, guess_valid,
    output guess_ack
  );
endinterface

// File: rtl/lock_round_ctrl.sv
// Lock game round sequencer: latches the coder's code, then gives the breaker
// MAX_TRIES guesses within TIME_LIMIT ticks and reports win/lose.
// Optional feature macro: LOCK_HINT_EN (above/below hint from a magnitude
// compare of guess versus code; when undefined, hint is tied to 00).
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start
// SET   | waiting for the coder's code; outcome and hint cleared
// PLAY  | breaker turn, timer running, waiting for a guess
// CHECK | one cycle: compare latched guess, pulse guess_ack
// WIN   | code broken, win held until start
// LOSE  | tries or time exhausted, lose held until start
module lock_round_ctrl #(
  parameter int CODE_W     = 4,
  parameter int MAX_TRIES  = 3,
  parameter int TIME_LIMIT = 10
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               tick,
  lock_round_if.slave                        bus,
  output logic [2:0]                         state,
  output logic [$clog2(MAX_TRIES+1)-1:0]     tries_left,
  output logic [$clog2(TIME_LIMIT+1)-1:0]    time_left,
  output logic                               win,
  output logic                               lose,
  output logic [1:0]                         hint
);

  localparam int TRY_W  = $clog2(MAX_TRIES + 1);
  localparam int TIME_W = $clog2(TIME_LIMIT + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SET   = 3'd1,
    S_PLAY  = 3'd2,
    S_CHECK = 3'd3,
    S_WIN   = 3'd4,
    S_LOSE  = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [CODE_W-1:0]   code_q, guess_q;
  logic [TRY_W-1:0]    tries_q;
  logic [TIME_W-1:0]   time_q;
  logic                time_last;
  logic                tick_expire;
  logic                enter_set;

  assign time_last   = (time_q == TIME_W'(1));
  assign tick_expire = tick && time_last;
  assign enter_set   = (state_q == S_IDLE || state_q == S_WIN || state_q == S_LOSE) && bus.start;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; a guess beats an expiring tick in the same cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_SET;
      S_SET:   if (bus.code_valid) state_d = S_PLAY;
      S_PLAY: begin
        if (bus.guess_valid)  state_d = S_CHECK;
        else if (tick_expire) state_d = S_LOSE;
      end
      S_CHECK: begin
        if (guess_q == code_q)          state_d = S_WIN;
        else if (tries_q <= TRY_W'(1))  state_d = S_LOSE;
        else                            state_d = S_PLAY;
      end
      S_WIN:   if (bus.start) state_d = S_SET;
      S_LOSE:  if (bus.start) state_d = S_SET;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore outputs decoded from the state flop, so no input-to-output path
  always_comb begin
    bus.guess_ack = (state_q == S_CHECK);
    win           = (state_q == S_WIN);
    lose          = (state_q == S_LOSE);
  end

  // Code/guess latches and the saturating try and time counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q  <= '0;
      guess_q <= '0;
      tries_q <= '0;
      time_q  <= '0;
    end else begin
      case (state_q)
        S_SET: begin
          if (bus.code_valid) begin
            code_q  <= bus.code_in;
            tries_q <= TRY_W'(MAX_TRIES);
            time_q  <= TIME_W'(TIME_LIMIT);
          end
        end
        S_PLAY: begin
          if (bus.guess_valid) guess_q <= bus.guess_in;
          if (tick && !(bus.guess_valid && time_last) && time_q != '0)
            time_q <= time_q - TIME_W'(1);
        end
        S_CHECK: begin
          if (guess_q != code_q && tries_q != '0)
            tries_q <= tries_q - TRY_W'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef LOCK_HINT_EN
  logic [1:0] hint_q;

  // Hint is computed from the incoming guess so it is already valid during
  // the CHECK cycle, alongside guess_ack; cleared whenever a round is set up
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hint_q <= 2'b00;
    end else if (enter_set) begin
      hint_q <= 2'b00;
    end else if (state_q == S_PLAY && bus.guess_valid) begin
      if (code_q > bus.guess_in)      hint_q <= 2'b01;
      else if (code_q < bus.guess_in) hint_q <= 2'b10;
      else                            hint_q <= 2'b00;
    end
  end

  assign hint = hint_q;
`else
  logic unused_enter_set;
  assign unused_enter_set = enter_set;
  assign hint = 2'b00;
`endif

  assign state      = state_q;
  assign tries_left = tries_q;
  assign time_left  = time_q;

endmodule
